// File: rtl/voice_sample_scheduler_pkg.sv
// rtl/voice_sample_scheduler_pkg.sv - shared constants and types for the voice sample scheduler
// Purpose: audio format, voice count, timeout and scheduler state encoding
//          shared by the scheduler, its frame divider and the voice bus interface.
// Ports: none (package).
package voice_sample_scheduler_pkg;

  localparam int AUDIO_BIT_WIDTH   = 16;
  localparam int AUDIO_CLOCK_HZ    = 16_934_400;
  localparam int AUDIO_SAMPLE_RATE = 44_100;
  localparam int NUM_VOICES        = 8;
  localparam int VOICE_TIMEOUT     = 32;

  typedef logic signed [AUDIO_BIT_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WAIT,
    OUTPUT
  } sched_state_t;

endpackage

// File: rtl/voice_sample_scheduler_if.sv
// rtl/voice_sample_scheduler_if.sv - shared voice request/response bus
// Purpose: one-hot request from the scheduler to the voices and the
//          sample/valid response from the requested voice.
// Signals:
//   voice_req    : one-hot request, scheduler -> voices
//   voice_sample : signed sample from the requested voice
//   voice_valid  : voice_sample is valid this cycle
interface voice_sample_scheduler_if;
  import voice_sample_scheduler_pkg::*;

  logic [NUM_VOICES-1:0] voice_req;
  sample_t               voice_sample;
  logic                  voice_valid;

  modport master (
    output voice_req,
    input  voice_sample,
    input  voice_valid
  );

  modport slave (
    input  voice_req,
    output voice_sample,
    output voice_valid
  );

endinterface

// File: rtl/voice_sample_scheduler_frame_tick_gen.sv
// rtl/voice_sample_scheduler_frame_tick_gen.sv - audio frame divider
// Purpose: counts audio clock cycles 0..TICKS-1 and flags the last one of
//          each frame as the frame start for the scheduler.
// Ports:
//   clock_16_934_400 : audio master clock
//   reset_l          : asynchronous active-low reset
//   frame_start_o    : high for one cycle every TICKS cycles
module voice_sample_scheduler_frame_tick_gen #(
  parameter int TICKS = 384
) (
  input  logic clock_16_934_400,
  input  logic reset_l,
  output logic frame_start_o
);

  localparam int CW = $clog2(TICKS);

  logic [CW-1:0] tick_count_q;
  logic [CW-1:0] tick_count_d;

  assign frame_start_o = (tick_count_q == CW'(TICKS - 1));

  always_comb begin
    tick_count_d = frame_start_o ? '0 : tick_count_q + 1'b1;
  end

  always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
    if (!reset_l) begin
      tick_count_q <= '0;
    end else begin
      tick_count_q <= tick_count_d;
    end
  end

endmodule

// File: rtl/voice_sample_scheduler.sv
// rtl/voice_sample_scheduler.sv - per-frame voice polling, mixing and saturation for the DAC
// Purpose: once per audio frame, polls each enabled voice over the shared bus,
//          sums the signed samples, shifts and saturates the sum and holds it
//          for the I2S driver until the next frame.
// Ports:
//   clock_16_934_400 : audio master clock
//   reset_l          : asynchronous active-low reset
//   voice_bus        : master side of the shared voice request/response bus
//   voice_active_i   : per-voice enable, latched at frame start
//   master_shift_i   : arithmetic right shift of the sum, latched at frame start
//   status_clear_i   : clears missed_voice_o and frame_overrun_o
//   audio_out_o      : saturated mixed sample, held between frames
//   sample_tick_o    : one-cycle pulse with each audio_out_o update
//   missed_voice_o   : sticky per-voice timeout flags
//   frame_overrun_o  : sticky, frame start seen while a frame was in progress
module voice_sample_scheduler
  import voice_sample_scheduler_pkg::*;
#(
  parameter int TICKS_PER_SAMPLE = AUDIO_CLOCK_HZ / AUDIO_SAMPLE_RATE,
  parameter int TIMEOUT          = VOICE_TIMEOUT
) (
  input  logic                    clock_16_934_400,
  input  logic                    reset_l,
  voice_sample_scheduler_if.master voice_bus,
  input  logic [NUM_VOICES-1:0]   voice_active_i,
  input  logic [2:0]              master_shift_i,
  input  logic                    status_clear_i,
  output sample_t                 audio_out_o,
  output logic                    sample_tick_o,
  output logic [NUM_VOICES-1:0]   missed_voice_o,
  output logic                    frame_overrun_o
);

  localparam int VI_W  = $clog2(NUM_VOICES);
  localparam int IDX_W = $clog2(NUM_VOICES + 1);
  localparam int WC_W  = $clog2(TIMEOUT);
  // Wide enough that NUM_VOICES full-scale samples never wrap.
  localparam int ACC_W = AUDIO_BIT_WIDTH + VI_W;

  localparam sample_t SAMPLE_MAX = {1'b0, {(AUDIO_BIT_WIDTH-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(AUDIO_BIT_WIDTH-1){1'b0}}};

  logic frame_start;

  sched_state_t            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WC_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [NUM_VOICES-1:0]   active_mask_q, active_mask_d;
  logic [2:0]              shift_q, shift_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [NUM_VOICES-1:0]   voice_req_q, voice_req_d;
  sample_t                 audio_out_q, audio_out_d;
  logic                    sample_tick_q, sample_tick_d;
  logic [NUM_VOICES-1:0]   missed_q, missed_d;
  logic                    overrun_q, overrun_d;

  logic signed [ACC_W-1:0]         acc_shifted;
  logic [ACC_W-AUDIO_BIT_WIDTH:0]  acc_top;
  sample_t                         acc_sat;

  voice_sample_scheduler_frame_tick_gen #(
    .TICKS (TICKS_PER_SAMPLE)
  ) u_frame_tick (
    .clock_16_934_400 (clock_16_934_400),
    .reset_l          (reset_l),
    .frame_start_o    (frame_start)
  );

  // The shifted sum fits the output only when every bit above the output
  // sign bit agrees with it; otherwise clip toward the sign of the sum.
  assign acc_shifted = acc_q >>> shift_q;
  assign acc_top     = acc_shifted[ACC_W-1:AUDIO_BIT_WIDTH-1];

  always_comb begin
    acc_sat = acc_shifted[AUDIO_BIT_WIDTH-1:0];
    if (acc_top != '0 && acc_top != '1) begin
      acc_sat = acc_shifted[ACC_W-1] ? SAMPLE_MIN : SAMPLE_MAX;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_cnt_d    = wait_cnt_q;
    active_mask_d = active_mask_q;
    shift_d       = shift_q;
    acc_d         = acc_q;
    voice_req_d   = voice_req_q;
    audio_out_d   = audio_out_q;
    sample_tick_d = 1'b0;
    // Clear first so that a set in the same cycle takes priority.
    missed_d      = status_clear_i ? '0 : missed_q;
    overrun_d     = status_clear_i ? 1'b0 : overrun_q;

    // A frame start during a frame is flagged and otherwise dropped.
    if (frame_start && state_q != IDLE) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          active_mask_d = voice_active_i;
          shift_d       = master_shift_i;
          acc_d         = '0;
          idx_d         = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_VOICES)) begin
          state_d = OUTPUT;
        end else if (active_mask_q[idx_q[VI_W-1:0]]) begin
          voice_req_d = {{(NUM_VOICES-1){1'b0}}, 1'b1} << idx_q[VI_W-1:0];
          wait_cnt_d  = '0;
          state_d     = WAIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WAIT: begin
        if (voice_bus.voice_valid) begin
          acc_d = acc_q + {{(ACC_W-AUDIO_BIT_WIDTH){voice_bus.voice_sample[AUDIO_BIT_WIDTH-1]}},
                           voice_bus.voice_sample};
          voice_req_d = '0;
          idx_d       = idx_q + 1'b1;
          state_d     = SCAN;
        end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
          missed_d[idx_q[VI_W-1:0]] = 1'b1;
          voice_req_d = '0;
          idx_d       = idx_q + 1'b1;
          state_d     = SCAN;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      OUTPUT: begin
        audio_out_d   = acc_sat;
        sample_tick_d = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      wait_cnt_q    <= '0;
      active_mask_q <= '0;
      shift_q       <= '0;
      acc_q         <= '0;
      voice_req_q   <= '0;
      audio_out_q   <= '0;
      sample_tick_q <= 1'b0;
      missed_q      <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_cnt_q    <= wait_cnt_d;
      active_mask_q <= active_mask_d;
      shift_q       <= shift_d;
      acc_q         <= acc_d;
      voice_req_q   <= voice_req_d;
      audio_out_q   <= audio_out_d;
      sample_tick_q <= sample_tick_d;
      missed_q      <= missed_d;
      overrun_q     <= overrun_d;
    end
  end

  assign voice_bus.voice_req = voice_req_q;
  assign audio_out_o         = audio_out_q;
  assign sample_tick_o       = sample_tick_q;
  assign missed_voice_o      = missed_q;
  assign frame_overrun_o     = overrun_q;

endmodule

// File: tb/tb_voice_sample_scheduler.sv
// tb/tb_voice_sample_scheduler.sv - self-checking bench for voice_sample_scheduler
module tb_voice_sample_scheduler;
  import voice_sample_scheduler_pkg::*;

  localparam int TO  = 32;
  localparam int TPS = 384;

  logic                  clock_16_934_400 = 1'b0;
  logic                  reset_l;
  logic [NUM_VOICES-1:0] voice_active_i;
  logic [2:0]            master_shift_i;
  logic                  status_clear_i;
  sample_t               audio_out_o;
  logic                  sample_tick_o;
  logic [NUM_VOICES-1:0] missed_voice_o;
  logic                  frame_overrun_o;

  sample_t               audio2;
  logic                  tick2;
  logic [NUM_VOICES-1:0] missed2;
  logic                  overrun2;

  int checks = 0;
  int errors = 0;
  int cyc;
  int onehot_err = 0;
  int tick2_cnt = 0;
  int delay_cfg [NUM_VOICES];
  int samp_cfg  [NUM_VOICES];
  logic [NUM_VOICES-1:0] exp_missed;

  voice_sample_scheduler_if bus ();
  voice_sample_scheduler_if bus2 ();

  always #5 clock_16_934_400 = ~clock_16_934_400;

  voice_sample_scheduler #(.TICKS_PER_SAMPLE(TPS), .TIMEOUT(TO)) dut (
    .clock_16_934_400 (clock_16_934_400),
    .reset_l          (reset_l),
    .voice_bus        (bus),
    .voice_active_i   (voice_active_i),
    .master_shift_i   (master_shift_i),
    .status_clear_i   (status_clear_i),
    .audio_out_o      (audio_out_o),
    .sample_tick_o    (sample_tick_o),
    .missed_voice_o   (missed_voice_o),
    .frame_overrun_o  (frame_overrun_o)
  );

  // Long-timeout instance with every voice silent: frames outlast the budget.
  voice_sample_scheduler #(.TICKS_PER_SAMPLE(TPS), .TIMEOUT(64)) dut2 (
    .clock_16_934_400 (clock_16_934_400),
    .reset_l          (reset_l),
    .voice_bus        (bus2),
    .voice_active_i   ({NUM_VOICES{1'b1}}),
    .master_shift_i   (3'd0),
    .status_clear_i   (1'b0),
    .audio_out_o      (audio2),
    .sample_tick_o    (tick2),
    .missed_voice_o   (missed2),
    .frame_overrun_o  (overrun2)
  );

  always @(posedge clock_16_934_400 or negedge reset_l) begin
    if (!reset_l) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic set_all(input int s, input int d);
    for (int v = 0; v < NUM_VOICES; v++) begin
      samp_cfg[v]  = s;
      delay_cfg[v] = d;
    end
  endtask

  // Voice responders: voice v answers d cycles after its request first appears
  // (d = 0 answers in the first request cycle). With no request the bus carries
  // random noise that the scheduler must ignore.
  initial begin
    int resp_cnt;
    int v;
    logic [NUM_VOICES-1:0] prev_req;
    resp_cnt = 0;
    prev_req = '0;
    bus.voice_valid  = 1'b0;
    bus.voice_sample = '0;
    bus2.voice_valid  = 1'b0;
    bus2.voice_sample = '0;
    forever begin
      @(negedge clock_16_934_400);
      if (bus.voice_req != '0 && bus.voice_req == prev_req) resp_cnt++;
      else resp_cnt = 0;
      prev_req = bus.voice_req;
      if ($onehot(bus.voice_req)) begin
        v = 0;
        for (int i = 0; i < NUM_VOICES; i++) if (bus.voice_req[i]) v = i;
        bus.voice_valid  = (resp_cnt == delay_cfg[v]);
        bus.voice_sample = bus.voice_valid ? sample_t'(samp_cfg[v]) : sample_t'($urandom);
      end else begin
        if (bus.voice_req != '0) onehot_err++;
        bus.voice_valid  = 1'($urandom);
        bus.voice_sample = sample_t'($urandom);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock_16_934_400);
      if (tick2) tick2_cnt++;
    end
  end

  // Silent long-timeout instance: frame at 384 ends at 906, start at 768 is
  // dropped as an overrun, later frames end at 1674 and 2442.
  initial begin
    while (cyc < 700) @(negedge clock_16_934_400);
    check("ovr2_early", overrun2, 0);
    while (cyc < 1000) @(negedge clock_16_934_400);
    check("ovr2_set", overrun2, 1);
    check("tick2_first", tick2_cnt, 1);
    check("audio2", audio2, 0);
    check("missed2", missed2, 8'hFF);
    while (cyc < 2500) @(negedge clock_16_934_400);
    check("tick2_third", tick2_cnt, 3);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic run_frame(input string tag, input logic [NUM_VOICES-1:0] act,
                           input logic [2:0] sh, input bit clr);
    int e, lat, sum, expv, n, bad_req;
    logic [NUM_VOICES-1:0] miss;
    sum = 0; lat = 2; miss = '0; bad_req = 0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!act[v]) lat += 1;
      else if (delay_cfg[v] < TO) begin sum += samp_cfg[v]; lat += delay_cfg[v] + 2; end
      else begin miss[v] = 1'b1; lat += 1 + TO; end
    end
    expv = clamp16(sum >>> sh);
    if (clr) exp_missed = '0;
    exp_missed |= miss;
    voice_active_i = act;
    master_shift_i = sh;
    status_clear_i = clr;
    e = ((cyc + TPS) / TPS) * TPS;
    n = 0;
    do begin
      @(negedge clock_16_934_400);
      n++;
      status_clear_i = 1'b0;
      if ((bus.voice_req & ~act) != '0) bad_req++;
      if (cyc >= e) begin
        voice_active_i = NUM_VOICES'($urandom);
        master_shift_i = 3'($urandom);
      end
    end while (!sample_tick_o && n < 3 * TPS);
    check({tag, " tick"}, sample_tick_o, 1);
    check({tag, " lat"}, cyc, e + lat);
    check({tag, " audio"}, audio_out_o, expv);
    check({tag, " missed"}, missed_voice_o, exp_missed);
    check({tag, " ovr"}, frame_overrun_o, 0);
    check({tag, " req"}, bad_req, 0);
    @(negedge clock_16_934_400);
    check({tag, " tick_once"}, sample_tick_o, 0);
  endtask

  initial begin
    int n;
    sample_t t;
    reset_l = 1'b0;
    voice_active_i = '0;
    master_shift_i = '0;
    status_clear_i = 1'b0;
    exp_missed = '0;
    set_all(0, 0);
    repeat (3) @(negedge clock_16_934_400);
    check("rst audio", audio_out_o, 0);
    check("rst tick", sample_tick_o, 0);
    check("rst req", bus.voice_req, 0);
    check("rst missed", missed_voice_o, 0);
    check("rst ovr", frame_overrun_o, 0);
    reset_l = 1'b1;

    samp_cfg[0] = 1000;  delay_cfg[0] = 2;
    samp_cfg[1] = -300;  delay_cfg[1] = 2;
    run_frame("two_voice", 8'h03, 3'd0, 1'b0);
    set_all(32767, 0);
    run_frame("sat_pos", 8'hFF, 3'd0, 1'b0);
    run_frame("sat_pos_sh3", 8'hFF, 3'd3, 1'b0);
    set_all(-32768, 0);
    run_frame("sat_neg", 8'hFF, 3'd0, 1'b0);
    set_all(100, 0);
    delay_cfg[2] = 1000;
    run_frame("timeout_v2", 8'h0D, 3'd0, 1'b0);
    run_frame("clear_idle", 8'h00, 3'd0, 1'b1);
    set_all(0, 0);
    samp_cfg[1] = -5000; delay_cfg[1] = TO - 1;
    samp_cfg[4] = 7000;  delay_cfg[4] = TO;
    run_frame("edge_to", 8'h12, 3'd1, 1'b0);

    for (int f = 0; f < 14; f++) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        t = sample_t'($urandom);
        samp_cfg[v]  = ($urandom_range(0, 3) == 0) ? (t[0] ? 32767 : -32768) : int'(t);
        delay_cfg[v] = $urandom_range(0, TO + 4);
      end
      run_frame($sformatf("rand%0d", f), NUM_VOICES'($urandom), 3'($urandom),
                ($urandom_range(0, 3) == 0));
    end

    set_all(0, 0);
    samp_cfg[0] = 1234;
    delay_cfg[6] = 1000;
    run_frame("pre_rst", 8'h41, 3'd0, 1'b0);

    set_all(0, 0);
    delay_cfg[5] = 1000;
    voice_active_i = 8'h20;
    master_shift_i = 3'd0;
    n = 0;
    while (bus.voice_req != 8'h20 && n < 2 * TPS) begin
      @(negedge clock_16_934_400);
      n++;
    end
    check("rst_req_seen", bus.voice_req, 8'h20);
    repeat (5) @(negedge clock_16_934_400);
    #2 reset_l = 1'b0;
    #1;
    check("midrst req", bus.voice_req, 0);
    check("midrst audio", audio_out_o, 0);
    check("midrst missed", missed_voice_o, 0);
    check("midrst ovr", frame_overrun_o, 0);
    check("midrst tick", sample_tick_o, 0);
    repeat (3) @(negedge clock_16_934_400);
    voice_active_i = '0;
    reset_l = 1'b1;
    n = 0;
    while (!sample_tick_o && n < 3 * TPS) begin
      @(negedge clock_16_934_400);
      n++;
    end
    check("postrst first_tick", cyc, TPS + NUM_VOICES + 2);
    check("postrst audio", audio_out_o, 0);
    check("postrst missed", missed_voice_o, 0);
    check("req_onehot", onehot_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
